blink_arbiter: RTL and testbench
================================

// Module: blink_arbiter
// PURPOSE
//  Shares one LED blink driver among NREQ requesters. Each requester asks for
//  a burst of N blinks. A round-robin arbiter grants the driver to one
//  requester at a time, and an FSM times the ON/OFF phases of the burst.
//  Sits between status sources (error, heartbeat, activity) and the board LED.
//  Liveness: a request held high is granted within NREQ-1 foreign bursts.
// PARAMETERS
//  NREQ     4   number of requesters (2..8)
//  BBITS    4   width of per-requester blink count
//  CBITS    8   width of phase timer
//  ON_CYC   4   cycles LED is high per blink (1..2^CBITS-1)
//  OFF_CYC  4   cycles LED is low per blink (1..2^CBITS-1)
//  GAP_CYC  8   idle cycles after a burst; used only with BLINK_ARB_GAP_EN (>=1)
// PORTS
//  clk     in   1           clock, rising edge
//  rst     in   1           asynchronous reset, active-high
//  req     in   NREQ        level request; held until matching done pulse
//  blinks  in   NREQ*BBITS  blink count of requester i = blinks[i*BBITS +: BBITS]
//  gnt     out  NREQ        one-hot grant, held for the whole burst
//  done    out  NREQ        one-cycle pulse, burst of requester i finished
//  led     out  1           LED drive
//  busy    out  1           1 when state != IDLE
// BEHAVIOUR
//  - Reset (async): state=IDLE, gnt=0, done=0, led=0, busy=0, rr pointer=0,
//    remaining count=0, timer=0. Reset mid-burst aborts the burst immediately;
//    no done pulse is issued.
//  - All outputs are registered.
//  - States: IDLE, ON, OFF, GAP (GAP exists only with the macro).
//  - IDLE, edge with any eligible req:
//    - Pick the first set bit at or after the rr pointer, wrapping at NREQ.
//    - Set gnt[i]=1 and latch n=blinks slice i.
//    - Set rr pointer = (i+1) mod NREQ.
//    - If n>0: go to ON, led=1, timer=ON_CYC-1, remaining=n.
//    - If n==0: gnt is high for 1 cycle, led stays 0, then end-of-burst.
//  - ON: timer reaching 0 -> OFF, led=0, timer=OFF_CYC-1.
//  - OFF: timer reaching 0 -> remaining-1.
//    - Nonzero result: go to ON, led=1.
//    - Zero result: end-of-burst.
//  - End-of-burst (single edge):
//    - gnt=0, done[i]=1 for exactly 1 cycle.
//    - Next state is IDLE, or GAP when the macro is defined.
//  - Latency: req seen at edge t -> gnt and led high after edge t.
//    Burst occupies n*(ON_CYC+OFF_CYC) cycles; done is high in the next cycle.
//  - Masking: in the cycle done[i] is high, req[i] is masked from arbitration,
//    so a requester cannot be re-granted on its own stale request.
//  - req or blinks changing mid-burst is ignored; the burst always completes.
//  - A req dropped before it is granted is simply never served (no memory).
//  - Simultaneous reqs: round robin decides; at most one gnt bit is ever set.
//  - Counter arithmetic is unsigned; remaining never wraps below 0.
// CONFIGURATION
//  BLINK_ARB_GAP_EN
//    Defined: after end-of-burst, enter GAP for GAP_CYC cycles with led=0,
//    gnt=0, busy=1; then return to IDLE. This makes bursts visually separable.
//    Not defined: end-of-burst returns straight to IDLE, so a new grant can
//    start in the cycle after done. The GAP state and GAP_CYC logic are absent.
// TESTING
//  1. Single request, defaults, no macro: req[1]=1, blinks[1]=3 at t.
//     -> gnt=4'b0010 over t+1..t+24; led pattern 4 high / 4 low, three times;
//        done[1] high at t+25 only.
//  2. After reset, req[0] and req[2] rise together with blinks=1.
//     -> req 0 served first; then req 2 granted at done[0]+1 (no macro).
//  3. req=4'b1111 held, all blinks=1.
//     -> grant order 0,1,2,3,0,1; never two gnt bits set at once.
//  4. blinks[3]=0, req[3]=1.
//     -> gnt[3] high for 1 cycle, led stays 0, done[3] in the following cycle.
//  5. rst pulsed during the 2nd ON phase of a 3-blink burst.
//     -> gnt=0, led=0, busy=0, no done; next grant goes to the lowest-index req.
//  6. BLINK_ARB_GAP_EN, GAP_CYC=8, two requesters.
//     -> led=0 and gnt=0 for 8 cycles after done; second gnt at done+9.

Source files
------------

// File: rtl/blink_arbiter.sv
// Round-robin arbiter sharing one LED blink driver among NREQ requesters; an FSM times ON/OFF phases.
// Optional macro BLINK_ARB_GAP_EN inserts a GAP_CYC idle gap after every burst.
module blink_arbiter #(
  parameter int NREQ    = 4,
  parameter int BBITS   = 4,
  parameter int CBITS   = 8,
  parameter int ON_CYC  = 4,
  parameter int OFF_CYC = 4
`ifdef BLINK_ARB_GAP_EN
  , parameter int GAP_CYC = 8
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*BBITS-1:0] blinks,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  led,
  output logic                  busy
);

  localparam int PBITS = $clog2(NREQ);
  localparam logic [CBITS-1:0] ON_LOAD  = CBITS'(ON_CYC - 1);
  localparam logic [CBITS-1:0] OFF_LOAD = CBITS'(OFF_CYC - 1);
`ifdef BLINK_ARB_GAP_EN
  localparam logic [CBITS-1:0] GAP_LOAD = CBITS'(GAP_CYC - 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2
`ifdef BLINK_ARB_GAP_EN
    , S_GAP = 2'd3
`endif
  } state_e;

  state_e            state_q, state_d;
  logic [CBITS-1:0]  timer_q, timer_d;
  logic [BBITS-1:0]  rem_q, rem_d;
  logic [PBITS-1:0]  rr_q, rr_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic              led_q, led_d;
  logic              busy_q, busy_d;

  logic [NREQ-1:0]   elig_s;
  logic [PBITS-1:0]  sel_s;
  logic              found_s;
  logic [BBITS-1:0]  n_s;
  logic              start_s;
  logic              eob_s;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      rem_q   <= '0;
      rr_q    <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      rem_q   <= rem_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
    end
  end

  // Round-robin pick; a requester whose done is showing cannot win on its stale request
  always_comb begin
    int j;
    elig_s  = req & ~done_q;
    found_s = 1'b0;
    sel_s   = '0;
    j       = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(rr_q) + k) % NREQ;
      if (!found_s && elig_s[j]) begin
        found_s = 1'b1;
        sel_s   = PBITS'(j);
      end else begin
        found_s = found_s;
      end
    end
    n_s = blinks[int'(sel_s)*BBITS +: BBITS];
  end

  // Next-state, phase timer, remaining count and rr pointer
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    rem_d   = rem_q;
    rr_d    = rr_q;
    start_s = 1'b0;
    eob_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (found_s) begin
          start_s = 1'b1;
          if (sel_s == PBITS'(NREQ - 1)) begin
            rr_d = '0;
          end else begin
            rr_d = sel_s + PBITS'(1);
          end
          if (n_s != '0) begin
            state_d = S_ON;
            timer_d = ON_LOAD;
            rem_d   = n_s;
          end else begin
            // zero-blink request: one granted cycle in OFF with nothing left, then end
            state_d = S_OFF;
            timer_d = '0;
            rem_d   = '0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ON: begin
        if (timer_q == '0) begin
          state_d = S_OFF;
          timer_d = OFF_LOAD;
        end else begin
          timer_d = timer_q - CBITS'(1);
        end
      end
      S_OFF: begin
        if (timer_q != '0) begin
          timer_d = timer_q - CBITS'(1);
        end else if (rem_q > BBITS'(1)) begin
          rem_d   = rem_q - BBITS'(1);
          state_d = S_ON;
          timer_d = ON_LOAD;
        end else begin
          eob_s = 1'b1;
          rem_d = '0;
`ifdef BLINK_ARB_GAP_EN
          state_d = S_GAP;
          timer_d = GAP_LOAD;
`else
          state_d = S_IDLE;
          timer_d = '0;
`endif
        end
      end
`ifdef BLINK_ARB_GAP_EN
      S_GAP: begin
        if (timer_q == '0) begin
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q - CBITS'(1);
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
        rem_d   = '0;
      end
    endcase
  end

  // Registered output values derived from the upcoming state
  always_comb begin
    if (start_s) begin
      gnt_d = {{(NREQ-1){1'b0}}, 1'b1} << sel_s;
    end else if (eob_s) begin
      gnt_d = '0;
    end else begin
      gnt_d = gnt_q;
    end
    if (eob_s) begin
      done_d = gnt_q;
    end else begin
      done_d = '0;
    end
    led_d  = (state_d == S_ON);
    busy_d = (state_d != S_IDLE);
  end

  assign gnt  = gnt_q;
  assign done = done_q;
  assign led  = led_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_blink_arbiter.sv
// Directed self-checking bench for blink_arbiter with default parameters.
// The gap scenario runs only when BLINK_ARB_GAP_EN is defined.
module tb_blink_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] blinks;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        led;
  logic        busy;

  int checks = 0;
  int errors = 0;

  blink_arbiter dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .blinks (blinks),
    .gnt    (gnt),
    .done   (done),
    .led    (led),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_gnt"},  32'(gnt),  32'h0);
    chk({tag, "_done"}, 32'(done), 32'h0);
    chk({tag, "_led"},  32'(led),  32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst    = 1'b1;
    req    = 4'b0000;
    blinks = 16'h0000;
    run(2);
    chk_idle("reset");
    rst = 1'b0;
    tick();
    chk_idle("post_reset");

    // 1: single 3-blink burst on requester 1
    req    = 4'b0010;
    blinks = 16'h0030;
    for (int k = 1; k <= 24; k++) begin
      tick();
      chk("t1_gnt",  32'(gnt),  32'h2);
      chk("t1_led",  32'(led),  32'(((k - 1) % 8) < 4));
      chk("t1_done", 32'(done), 32'h0);
      chk("t1_busy", 32'(busy), 32'h1);
    end
    tick();
    chk("t1_done_pulse", 32'(done), 32'h2);
    chk("t1_gnt_off",    32'(gnt),  32'h0);
    chk("t1_led_off",    32'(led),  32'h0);
    // req[1] still high here: masked by its own done pulse
    tick();
    chk("t1_mask_gnt",  32'(gnt),  32'h0);
    chk("t1_mask_done", 32'(done), 32'h0);
    chk("t1_mask_busy", 32'(busy), 32'h0);
    req = 4'b0000;
    tick();
    chk_idle("t1_end");

    // 2: req 0 and 2 together after reset
    pulse_reset();
    chk_idle("t2_reset");
    req    = 4'b0101;
    blinks = 16'h0101;
    tick();
    chk("t2_gnt0",  32'(gnt), 32'h1);
    chk("t2_led0",  32'(led), 32'h1);
    run(7);
    chk("t2_gnt0_end", 32'(gnt), 32'h1);
    chk("t2_led0_end", 32'(led), 32'h0);
    tick();
    chk("t2_done0", 32'(done), 32'h1);
    chk("t2_gap0",  32'(gnt),  32'h0);
    req = 4'b0100;
    tick();
    chk("t2_gnt2",  32'(gnt),  32'h4);
    chk("t2_done2_clr", 32'(done), 32'h0);
    run(7);
    chk("t2_gnt2_end", 32'(gnt), 32'h4);
    tick();
    chk("t2_done2", 32'(done), 32'h4);
    req = 4'b0000;
    tick();
    chk_idle("t2_end");

    // 3: all four requesting, order 0,1,2,3,0,1
    pulse_reset();
    req    = 4'b1111;
    blinks = 16'h1111;
    for (int g = 0; g < 6; g++) begin
      tick();
      chk("t3_gnt_start", 32'(gnt), 32'(1 << (g % 4)));
      for (int c = 0; c < 7; c++) begin
        tick();
        chk("t3_gnt_hold", 32'(gnt), 32'(1 << (g % 4)));
      end
      tick();
      chk("t3_done", 32'(done), 32'(1 << (g % 4)));
      chk("t3_gnt_clr", 32'(gnt), 32'h0);
    end
    req = 4'b0000;
    tick();
    chk_idle("t3_end");

    // 4: zero-blink request on requester 3
    req    = 4'b1000;
    blinks = 16'h0000;
    tick();
    chk("t4_gnt",  32'(gnt),  32'h8);
    chk("t4_led",  32'(led),  32'h0);
    chk("t4_busy", 32'(busy), 32'h1);
    chk("t4_done_early", 32'(done), 32'h0);
    tick();
    chk("t4_done", 32'(done), 32'h8);
    chk("t4_gnt_clr", 32'(gnt), 32'h0);
    chk("t4_led_off", 32'(led), 32'h0);
    req = 4'b0000;
    tick();
    chk_idle("t4_end");

    // 5: reset during second ON phase of a 3-blink burst on requester 2
    req    = 4'b0100;
    blinks = 16'h0300;
    tick();
    chk("t5_gnt", 32'(gnt), 32'h4);
    run(9);
    chk("t5_led_on2", 32'(led), 32'h1);
    chk("t5_gnt_mid", 32'(gnt), 32'h4);
    rst = 1'b1;
    #1;
    chk_idle("t5_async");
    req    = 4'b1010;
    blinks = 16'h1010;
    tick();
    chk_idle("t5_held");
    rst = 1'b0;
    tick();
    chk("t5_regnt", 32'(gnt), 32'h2);
    chk("t5_nodone", 32'(done), 32'h0);
    run(7);
    chk("t5_nodone_burst", 32'(done), 32'h0);
    tick();
    chk("t5_done", 32'(done), 32'h2);
    req = 4'b0000;
    tick();
    chk_idle("t5_end");

`ifdef BLINK_ARB_GAP_EN
    // 6: idle gap between two bursts
    pulse_reset();
    req    = 4'b0011;
    blinks = 16'h0011;
    tick();
    chk("t6_gnt0", 32'(gnt), 32'h1);
    run(7);
    tick();
    chk("t6_done0", 32'(done), 32'h1);
    req = 4'b0010;
    for (int c = 1; c <= 8; c++) begin
      tick();
      chk("t6_gap_gnt",  32'(gnt),  32'h0);
      chk("t6_gap_led",  32'(led),  32'h0);
      chk("t6_gap_busy", 32'(busy), 32'(c < 8));
    end
    tick();
    chk("t6_gnt1", 32'(gnt), 32'h2);
    req = 4'b0000;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
